// File: rtl/signed_comparator_pkg.sv
// signed_comparator_pkg: shared compare result encoding and default operand width
package signed_comparator_pkg;
    typedef enum logic [1:0] {CMP_LT, CMP_EQ, CMP_GT} cmp_t;
    localparam int DEF_WIDTH = 4;
    function automatic cmp_t to_cmp(input logic less, input logic eq);
        return eq ? CMP_EQ : (less ? CMP_LT : CMP_GT);
    endfunction
endpackage

// File: rtl/signed_comparator_if.sv
// signed_comparator_if: operand/enable inputs and registered compare flags
interface signed_comparator_if #(parameter int WIDTH = 4) ();
    logic             en;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out;
    logic             eq;
    logic             gt;
    logic             valid;
    modport master (output en, a, b, input out, eq, gt, valid);
    modport slave (input en, a, b, output out, eq, gt, valid);
endinterface

// File: rtl/signed_comparator_cmp_core.sv
// signed_comparator_cmp_core: combinational less/equal, sign-split rule avoids any subtraction
module signed_comparator_cmp_core #(
    parameter int WIDTH = 4,
    parameter bit SIGNED = 1'b1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             less,
    output logic             eq
);
    logic sa, sb, mag_lt;
    always_comb begin
        sa = a[WIDTH-1];
        sb = b[WIDTH-1];
        mag_lt = a[WIDTH-2:0] < b[WIDTH-2:0];
        less = SIGNED ? ((sa != sb) ? sa : mag_lt) : (a < b);
        eq = a == b;
    end
endmodule

// File: rtl/signed_comparator.sv
// signed_comparator: one-cycle registered compare of a/b with enable-gated hold
module signed_comparator
    import signed_comparator_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter bit SIGNED = 1'b1
) (
    input logic clk,
    input logic reset,
    signed_comparator_if.slave bus
);
    logic less, eq;
    cmp_t res;
    signed_comparator_cmp_core #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_core (
        .a(bus.a),
        .b(bus.b),
        .less(less),
        .eq(eq)
    );
    assign res = to_cmp(less, eq);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.out <= 1'b0;
            bus.eq <= 1'b0;
            bus.gt <= 1'b0;
            bus.valid <= 1'b0;
        end else begin
            bus.valid <= bus.en;
            if (bus.en) begin
                bus.out <= res == CMP_LT;
                bus.eq <= res == CMP_EQ;
                bus.gt <= res == CMP_GT;
            end
        end
    end
endmodule

// File: tb/tb_signed_comparator.sv
// tb_signed_comparator: signed and unsigned instances checked against an integer-arithmetic model
module tb_signed_comparator;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic en = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    int total = 0;
    int bad = 0;
    bit mon = 1'b0;
    logic [3:0] exp_s = '0;
    logic [3:0] exp_u = '0;

    signed_comparator_if #(.WIDTH(4)) bs ();
    signed_comparator_if #(.WIDTH(4)) bu ();
    assign bs.en = en;
    assign bs.a = a;
    assign bs.b = b;
    assign bu.en = en;
    assign bu.a = a;
    assign bu.b = b;

    signed_comparator #(.WIDTH(4), .SIGNED(1'b1)) dut_s (.clk(clk), .reset(reset), .bus(bs));
    signed_comparator #(.WIDTH(4), .SIGNED(1'b0)) dut_u (.clk(clk), .reset(reset), .bus(bu));

    initial forever #5 clk = ~clk;

    // reference: compare the operands as plain integers; returns {lt,eq,gt}
    function automatic logic [2:0] ref_cmp(input logic [3:0] x, input logic [3:0] y, input bit sgn);
        int ix, iy;
        if (sgn) begin
            ix = int'($signed(x));
            iy = int'($signed(y));
        end else begin
            ix = int'(x);
            iy = int'(y);
        end
        return {ix < iy, ix == iy, ix > iy};
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_s <= '0;
            exp_u <= '0;
        end else begin
            exp_s <= en ? {ref_cmp(a, b, 1'b1), 1'b1} : {exp_s[3:1], 1'b0};
            exp_u <= en ? {ref_cmp(a, b, 1'b0), 1'b1} : {exp_u[3:1], 1'b0};
        end
    end

    task automatic chk(input string n, input logic [3:0] act, input logic [3:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got{out,eq,gt,valid}=%b want=%b a=%b b=%b t=%0t", n, act, want, a, b, $time);
        end
    endtask

    task automatic chk_one(input string n, input logic [3:0] act);
        if (act[0]) begin
            total++;
            if ($countones(act[3:1]) != 1) begin
                bad++;
                $display("FAIL %s got{out,eq,gt}=%b want exactly one set", n, act[3:1]);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon) begin
            chk("model_s", {bs.out, bs.eq, bs.gt, bs.valid}, exp_s);
            chk("model_u", {bu.out, bu.eq, bu.gt, bu.valid}, exp_u);
            chk_one("onehot_s", {bs.out, bs.eq, bs.gt, bs.valid});
            chk_one("onehot_u", {bu.out, bu.eq, bu.gt, bu.valid});
        end
    end

    task automatic step(input logic [3:0] x, input logic [3:0] y, input logic e);
        a = x;
        b = y;
        en = e;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        chk("reset_hold_s", {bs.out, bs.eq, bs.gt, bs.valid}, 4'b0000);
        reset = 1'b0;
        mon = 1'b1;
        step(4'b0000, 4'b0000, 1'b1);
        chk("zero_eq", {bs.out, bs.eq, bs.gt, bs.valid}, 4'b0101);
        step(4'b0001, 4'b1110, 1'b1);
        chk("mix_gt_s", {bs.out, bs.eq, bs.gt, bs.valid}, 4'b0011);
        chk("mix_lt_u", {bu.out, bu.eq, bu.gt, bu.valid}, 4'b1001);
        step(4'b1100, 4'b0010, 1'b1);
        chk("mix_lt_s", {bs.out, bs.eq, bs.gt, bs.valid}, 4'b1001);
        step(4'b1110, 4'b1011, 1'b1);
        chk("neg_gt", {bs.out, bs.eq, bs.gt, bs.valid}, 4'b0011);
        step(4'b1111, 4'b1110, 1'b1);
        chk("neg_gt2", {bs.out, bs.eq, bs.gt, bs.valid}, 4'b0011);
        step(4'b1111, 4'b1111, 1'b1);
        chk("neg_eq", {bs.out, bs.eq, bs.gt, bs.valid}, 4'b0101);
        step(4'b1000, 4'b0111, 1'b1);
        chk("min_lt_max_s", {bs.out, bs.eq, bs.gt, bs.valid}, 4'b1001);
        chk("min_gt_max_u", {bu.out, bu.eq, bu.gt, bu.valid}, 4'b0011);
        step(4'b0111, 4'b1000, 1'b1);
        chk("max_gt_min_s", {bs.out, bs.eq, bs.gt, bs.valid}, 4'b0011);
        step(4'b1000, 4'b1000, 1'b1);
        chk("min_eq", {bs.out, bs.eq, bs.gt, bs.valid}, 4'b0101);
        step(4'b0110, 4'b0111, 1'b1);
        chk("pos_lt", {bs.out, bs.eq, bs.gt, bs.valid}, 4'b1001);
        step(4'b0111, 4'b0110, 1'b0);
        chk("hold_en0", {bs.out, bs.eq, bs.gt, bs.valid}, 4'b1000);
        step(4'b0101, 4'b0101, 1'b1);
        #2 reset = 1'b1;
        #1 chk("async_rst_s", {bs.out, bs.eq, bs.gt, bs.valid}, 4'b0000);
        chk("async_rst_u", {bu.out, bu.eq, bu.gt, bu.valid}, 4'b0000);
        @(negedge clk);
        chk("rst_discard", {bs.out, bs.eq, bs.gt, bs.valid}, 4'b0000);
        reset = 1'b0;
        step(4'b0000, 4'b0000, 1'b1);
        chk("post_rst_eq", {bs.out, bs.eq, bs.gt, bs.valid}, 4'b0101);
        for (int i = 0; i < 1000; i++)
            step(4'($urandom), 4'($urandom), $urandom_range(3, 0) != 0);
        mon = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
